vend_dispense_sequencer: RTL and testbench

Sequences the physical payout after a completed vend. It accepts one order (candy count, beg-coin change count, obeg-coin flag) from the vend controller through a valid/ready handshake. It then drives the candy motor, beg hopper and obeg hopper one item at a time, and waits for a sensor acknowledge per item. It sits between the vend controller outputs and the actuator pins, and reports busy/done/fault back to the control and display logic.

---
 rtl/vend_dispense_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_vend_dispense_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispense_sequencer.sv
// Payout sequencer: takes one vend order (candies, beg coins, obeg coin) and
// drives the candy motor and the two coin hoppers one item at a time. Each
// item waits for its drop/exit sensor acknowledge. A missing acknowledge
// latches a fault that only fault_clr releases.
module vend_dispense_sequencer #(
    parameter int PULSE_W = 4,    // actuator drive pulse length in clk cycles
    parameter int TIMEOUT = 200,  // max wait cycles for an item acknowledge
    parameter int TMR_W   = 8     // timer width, holds max(PULSE_W, TIMEOUT)
) (
    input  logic       clk,
    input  logic       reset,        // asynchronous, active-low
    input  logic       order_valid,
    output logic       order_ready,
    input  logic [2:0] order_candy,
    input  logic [2:0] order_beg,
    input  logic       order_obeg,
    input  logic       candy_ack,
    input  logic       coin_ack,
    input  logic       fault_clr,
    output logic       candy_drv,
    output logic       beg_drv,
    output logic       obeg_drv,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] candy_left,
    output logic [2:0] beg_left
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        C_PULSE = 4'd1,
        C_WAIT  = 4'd2,
        B_PULSE = 4'd3,
        B_WAIT  = 4'd4,
        O_PULSE = 4'd5,
        O_WAIT  = 4'd6,
        DONE    = 4'd7,
        FAULT   = 4'd8
    } state_t;

    // Stage codes double as the fault_code values reported to the display.
    localparam logic [1:0] STG_NONE  = 2'd0;
    localparam logic [1:0] STG_CANDY = 2'd1;
    localparam logic [1:0] STG_BEG   = 2'd2;
    localparam logic [1:0] STG_OBEG  = 2'd3;

    // Last timer value of a drive pulse and of an acknowledge wait window.
    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_W - 1);
    localparam logic [TMR_W-1:0] WAIT_LAST  = TMR_W'(TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [TMR_W-1:0] tmr_reg, tmr_next;
    logic [2:0]       candy_left_reg, candy_left_next;
    logic [2:0]       beg_left_reg, beg_left_next;
    logic             obeg_reg, obeg_next;
    logic             ack_seen_reg, ack_seen_next;
    logic [1:0]       fault_code_reg, fault_code_next;

    logic [1:0]       cur_stage;
    logic             in_pulse;
    logic             in_wait;
    logic             cur_ack;
    logic             item_complete;
    logic [2:0]       drv_vec;

    // First stage that still has work, in payout order candy -> beg -> obeg.
    function automatic state_t first_stage(input logic [2:0] c,
                                           input logic [2:0] b,
                                           input logic       o);
        state_t s;
        if (c != 3'd0) begin
            s = C_PULSE;
        end else if (b != 3'd0) begin
            s = B_PULSE;
        end else if (o) begin
            s = O_PULSE;
        end else begin
            s = DONE;
        end
        return s;
    endfunction

    // Wait state that follows a given pulse state.
    function automatic state_t wait_of(input state_t s);
        state_t w;
        case (s)
            C_PULSE: w = C_WAIT;
            B_PULSE: w = B_WAIT;
            O_PULSE: w = O_WAIT;
            default: w = IDLE;
        endcase
        return w;
    endfunction

    // Decode which payout stage is active and whether it is driving or waiting.
    always_comb begin
        cur_stage = STG_NONE;
        in_pulse  = 1'b0;
        in_wait   = 1'b0;
        case (state_reg)
            C_PULSE: begin cur_stage = STG_CANDY; in_pulse = 1'b1; end
            C_WAIT:  begin cur_stage = STG_CANDY; in_wait  = 1'b1; end
            B_PULSE: begin cur_stage = STG_BEG;   in_pulse = 1'b1; end
            B_WAIT:  begin cur_stage = STG_BEG;   in_wait  = 1'b1; end
            O_PULSE: begin cur_stage = STG_OBEG;  in_pulse = 1'b1; end
            O_WAIT:  begin cur_stage = STG_OBEG;  in_wait  = 1'b1; end
            default: ;
        endcase
    end

    // Only the sensor belonging to the active stage counts; the coin sensor
    // is shared by both hoppers.
    always_comb begin
        cur_ack = 1'b0;
        if (cur_stage == STG_CANDY) begin
            cur_ack = candy_ack;
        end else if (cur_stage != STG_NONE) begin
            cur_ack = coin_ack;
        end
    end

    // Drives decode straight from the state register so an asynchronous
    // reset drops them without waiting for a clock; one stage at a time.
    for (genvar gi = 0; gi < 3; gi++) begin : g_drv
        assign drv_vec[gi] = in_pulse && (cur_stage == 2'(gi + 1));
    end

    assign candy_drv   = drv_vec[0];
    assign beg_drv     = drv_vec[1];
    assign obeg_drv    = drv_vec[2];

    assign order_ready = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign fault       = (state_reg == FAULT);
    assign fault_code  = fault_code_reg;
    assign candy_left  = candy_left_reg;
    assign beg_left    = beg_left_reg;

    // Next-state logic: order accept, pulse timing, ack wait / timeout,
    // then item bookkeeping and selection of the next stage.
    always_comb begin
        state_next      = state_reg;
        tmr_next        = tmr_reg;
        candy_left_next = candy_left_reg;
        beg_left_next   = beg_left_reg;
        obeg_next       = obeg_reg;
        ack_seen_next   = ack_seen_reg;
        fault_code_next = fault_code_reg;
        item_complete   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (order_valid) begin
                    candy_left_next = order_candy;
                    beg_left_next   = order_beg;
                    obeg_next       = order_obeg;
                    tmr_next        = '0;
                    ack_seen_next   = 1'b0;
                    state_next      = first_stage(order_candy, order_beg, order_obeg);
                end
            end

            C_PULSE, B_PULSE, O_PULSE: begin
                // An early ack is remembered; extra acks for the same item
                // just re-set the same flag.
                if (cur_ack) begin
                    ack_seen_next = 1'b1;
                end
                if (tmr_reg == PULSE_LAST) begin
                    tmr_next      = '0;
                    ack_seen_next = 1'b0;
                    if (ack_seen_reg || cur_ack) begin
                        item_complete = 1'b1;
                    end else begin
                        state_next = wait_of(state_reg);
                    end
                end else begin
                    tmr_next = tmr_reg + 1'b1;
                end
            end

            C_WAIT, B_WAIT, O_WAIT: begin
                // An ack on the final wait cycle still beats the timeout.
                if (cur_ack) begin
                    item_complete = 1'b1;
                end else if (tmr_reg == WAIT_LAST) begin
                    state_next      = FAULT;
                    fault_code_next = cur_stage;
                end else begin
                    tmr_next = tmr_reg + 1'b1;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            FAULT: begin
                // Abandon the order: counts are dropped, nothing is retried.
                if (fault_clr) begin
                    state_next      = IDLE;
                    fault_code_next = STG_NONE;
                    candy_left_next = 3'd0;
                    beg_left_next   = 3'd0;
                    obeg_next       = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // One item delivered: count it and pick the next pulse or finish.
        if (item_complete) begin
            tmr_next      = '0;
            ack_seen_next = 1'b0;
            case (cur_stage)
                STG_CANDY: begin
                    candy_left_next = candy_left_reg - 3'd1;
                    if (candy_left_reg != 3'd1) begin
                        state_next = C_PULSE;
                    end else begin
                        state_next = first_stage(3'd0, beg_left_reg, obeg_reg);
                    end
                end
                STG_BEG: begin
                    beg_left_next = beg_left_reg - 3'd1;
                    if (beg_left_reg != 3'd1) begin
                        state_next = B_PULSE;
                    end else begin
                        state_next = first_stage(3'd0, 3'd0, obeg_reg);
                    end
                end
                STG_OBEG: begin
                    obeg_next  = 1'b0;
                    state_next = DONE;
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            tmr_reg        <= '0;
            candy_left_reg <= 3'd0;
            beg_left_reg   <= 3'd0;
            obeg_reg       <= 1'b0;
            ack_seen_reg   <= 1'b0;
            fault_code_reg <= 2'd0;
        end else begin
            state_reg      <= state_next;
            tmr_reg        <= tmr_next;
            candy_left_reg <= candy_left_next;
            beg_left_reg   <= beg_left_next;
            obeg_reg       <= obeg_next;
            ack_seen_reg   <= ack_seen_next;
            fault_code_reg <= fault_code_next;
        end
    end

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Bench for vend_dispense_sequencer: directed orders, expected payout
// events queued by the stimulus, checked by an independent monitor.
module tb_vend_dispense_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       order_valid = 1'b0;
    logic       order_ready;
    logic [2:0] order_candy = 3'd0;
    logic [2:0] order_beg = 3'd0;
    logic       order_obeg = 1'b0;
    logic       candy_ack = 1'b0;
    logic       coin_ack = 1'b0;
    logic       fault_clr = 1'b0;
    logic       candy_drv, beg_drv, obeg_drv;
    logic       busy, done, fault;
    logic [1:0] fault_code;
    logic [2:0] candy_left, beg_left;

    vend_dispense_sequencer #(.PULSE_W(4), .TIMEOUT(200), .TMR_W(8)) dut (
        .clk(clk), .reset(reset),
        .order_valid(order_valid), .order_ready(order_ready),
        .order_candy(order_candy), .order_beg(order_beg), .order_obeg(order_obeg),
        .candy_ack(candy_ack), .coin_ack(coin_ack), .fault_clr(fault_clr),
        .candy_drv(candy_drv), .beg_drv(beg_drv), .obeg_drv(obeg_drv),
        .busy(busy), .done(done), .fault(fault), .fault_code(fault_code),
        .candy_left(candy_left), .beg_left(beg_left)
    );

    always #5 clk = ~clk;

    // Event kinds: 1 candy pulse, 2 beg pulse, 3 obeg pulse, 4 done, 5 fault.
    typedef struct {
        int kind;
        int width;
        int cl;
        int bl;
        int code;
    } ev_t;

    ev_t exp_q[$];
    int  pass_cnt = 0;
    int  total_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int kind, input int width, input int cl,
                           input int bl, input int code);
        ev_t e;
        e.kind = kind; e.width = width; e.cl = cl; e.bl = bl; e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic emit(input int kind, input int width, input int cl,
                        input int bl, input int code);
        ev_t e;
        if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_event: got kind %0d width %0d, expected none", kind, width);
        end else begin
            e = exp_q.pop_front();
            $display("txn kind=%0d width=%0d candy_left=%0d beg_left=%0d code=%0d",
                     kind, width, cl, bl, code);
            chk("ev_kind", kind, e.kind);
            if (e.kind <= 3) chk("ev_pulse_width", width, e.width);
            chk("ev_candy_left", cl, e.cl);
            chk("ev_beg_left", bl, e.bl);
            if (e.kind == 5) chk("ev_fault_code", code, e.code);
        end
    endtask

    // Monitor: turns DUT outputs into events and compares them with the queue.
    initial begin
        int       cur_kind = 0;
        int       cur_w = 0;
        int       cur_cl = 0;
        int       cur_bl = 0;
        int       k;
        logic     fault_prev = 1'b0;
        logic [2:0] drv;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cur_kind   = 0;
                fault_prev = 1'b0;
            end else begin
                drv = {obeg_drv, beg_drv, candy_drv};
                if (drv != 3'd0) begin
                    chk("drv_onehot", $countones(drv), 1);
                    k = candy_drv ? 1 : (beg_drv ? 2 : 3);
                    if (cur_kind == 0) begin
                        cur_kind = k; cur_w = 1; cur_cl = candy_left; cur_bl = beg_left;
                    end else if (k != cur_kind) begin
                        emit(cur_kind, cur_w, cur_cl, cur_bl, 0);
                        cur_kind = k; cur_w = 1; cur_cl = candy_left; cur_bl = beg_left;
                    end else begin
                        cur_w++;
                    end
                end else if (cur_kind != 0) begin
                    emit(cur_kind, cur_w, cur_cl, cur_bl, 0);
                    cur_kind = 0;
                end
                if (done) emit(4, 0, candy_left, beg_left, 0);
                if (fault && !fault_prev) emit(5, 0, candy_left, beg_left, fault_code);
                fault_prev = fault;
            end
        end
    end

    function automatic logic drv_sel(input int which);
        return (which == 1) ? candy_drv : ((which == 2) ? beg_drv : obeg_drv);
    endfunction

    task automatic wait_drv(input int which, input logic lvl, input string name);
        int n = 0;
        while (drv_sel(which) !== lvl && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (drv_sel(which) !== lvl) chk(name, int'(drv_sel(which)), int'(lvl));
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(done), 1);
    endtask

    task automatic pulse_ack(input int which);
        if (which == 1) candy_ack = 1'b1; else coin_ack = 1'b1;
        @(negedge clk);
        candy_ack = 1'b0;
        coin_ack  = 1'b0;
    endtask

    // Offer an order for one clock, then scramble the inputs while busy.
    task automatic send_order(input int c, input int b, input int o);
        @(negedge clk);
        order_candy = 3'(c);
        order_beg   = 3'(b);
        order_obeg  = 1'(o);
        order_valid = 1'b1;
        chk("order_ready_at_offer", int'(order_ready), 1);
        @(negedge clk);
        order_valid = 1'b0;
        order_candy = 3'd7;
        order_beg   = 3'd7;
        order_obeg  = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // Reset held with an order offered: idle outputs, nothing accepted.
        order_valid = 1'b1;
        order_candy = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_order_ready", int'(order_ready), 1);
            chk("rst_busy", int'(busy), 0);
            chk("rst_drv", int'({candy_drv, beg_drv, obeg_drv}), 0);
            chk("rst_candy_left", int'(candy_left), 0);
        end
        chk("rst_fault", int'({fault, fault_code}), 0);
        order_valid = 1'b0;
        order_candy = 3'd0;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);

        // Full order 2/3/1, ack on the second cycle of every wait.
        push_ev(1, 4, 2, 3, 0);
        push_ev(1, 4, 1, 3, 0);
        push_ev(2, 4, 0, 3, 0);
        push_ev(2, 4, 0, 2, 0);
        push_ev(2, 4, 0, 1, 0);
        push_ev(3, 4, 0, 0, 0);
        push_ev(4, 0, 0, 0, 0);
        send_order(2, 3, 1);
        for (int i = 0; i < 6; i++) begin
            int w;
            w = (i < 2) ? 1 : ((i < 5) ? 2 : 3);
            wait_drv(w, 1'b1, "full_drv_rise");
            wait_drv(w, 1'b0, "full_drv_fall");
            @(negedge clk);
            pulse_ack(w);
        end
        wait_done("full_done");
        chk("full_busy_at_done", int'(busy), 1);
        @(negedge clk);
        chk("full_ready_after", int'(order_ready), 1);
        chk("full_busy_after", int'(busy), 0);

        // Zero order: done on the cycle right after accept.
        push_ev(4, 0, 0, 0, 0);
        send_order(0, 0, 0);
        chk("zero_done_next_cycle", int'(done), 1);
        @(negedge clk);
        chk("zero_done_one_cycle", int'(done), 0);
        chk("zero_ready", int'(order_ready), 1);

        // Single candy, ack in the third pulse cycle: wait state skipped.
        push_ev(1, 4, 1, 0, 0);
        push_ev(4, 0, 0, 0, 0);
        send_order(1, 0, 0);
        wait_drv(1, 1'b1, "early_drv_rise");
        @(negedge clk);
        @(negedge clk);
        pulse_ack(1);
        @(negedge clk);
        chk("early_done_after_pulse", int'(done), 1);
        chk("early_candy_left", int'(candy_left), 0);
        @(negedge clk);

        // Two beg coins, second never acknowledged: timeout fault.
        push_ev(2, 4, 0, 2, 0);
        push_ev(2, 4, 0, 1, 0);
        push_ev(5, 0, 0, 1, 2);
        send_order(0, 2, 0);
        wait_drv(2, 1'b1, "to_drv_rise1");
        wait_drv(2, 1'b0, "to_drv_fall1");
        pulse_ack(2);
        wait_drv(2, 1'b1, "to_drv_rise2");
        wait_drv(2, 1'b0, "to_drv_fall2");
        n = 0;
        while (!fault && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, 200);
        chk("fault_code", int'(fault_code), 2);
        chk("fault_beg_left", int'(beg_left), 1);
        chk("fault_busy", int'(busy), 1);
        chk("fault_ready", int'(order_ready), 0);
        @(negedge clk);
        chk("fault_held", int'(fault), 1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("clr_fault", int'(fault), 0);
        chk("clr_code", int'(fault_code), 0);
        chk("clr_beg_left", int'(beg_left), 0);
        chk("clr_busy", int'(busy), 0);
        chk("clr_no_done", int'(done), 0);

        // Reset in the middle of the second candy pulse.
        push_ev(1, 4, 3, 0, 0);
        send_order(3, 0, 0);
        wait_drv(1, 1'b1, "rst_mid_rise");
        wait_drv(1, 1'b0, "rst_mid_fall");
        pulse_ack(1);
        chk("rst_mid_second_pulse", int'(candy_drv), 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_drv_async", int'(candy_drv), 0);
        chk("rst_mid_candy_left", int'(candy_left), 0);
        chk("rst_mid_ready", int'(order_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        pulse_ack(1);
        @(negedge clk);
        chk("stray_ack_candy_left", int'(candy_left), 0);
        chk("stray_ack_busy", int'(busy), 0);

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
